// File: rtl/quick_spi_sequencer.sv
// Command queue and sequencer in front of quick_spi: buffers commands, issues them one at a time and
// returns read data through a response FIFO. Optional watchdog enabled by QUICK_SPI_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module quick_spi_sequencer #(
    parameter int NUMBER_OF_SLAVES      = 2,
    parameter int OUTGOING_DATA_WIDTH   = 16,
    parameter int INCOMING_DATA_WIDTH   = 8,
    parameter int CMD_FIFO_DEPTH        = 4,
    parameter int RSP_FIFO_DEPTH        = 4,
    parameter int INTER_TRANSACTION_GAP = 2
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES        = 1024
`endif
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave,
    input  logic                           cmd_operation,
    input  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
    output logic                           busy,
    output logic                           spi_enable,
    output logic                           spi_start_transaction,
    output logic [NUMBER_OF_SLAVES-1:0]    spi_slave,
    output logic                           spi_operation,
    output logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data,
    input  logic                           spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    ,
    output logic                           timeout_error,
    input  logic                           error_clear
`endif
);

    localparam int CMD_W = NUMBER_OF_SLAVES + 1 + OUTGOING_DATA_WIDTH;
    localparam int CAW   = $clog2(CMD_FIFO_DEPTH);
    localparam int CCW   = CAW + 1;
    localparam int RAW   = $clog2(RSP_FIFO_DEPTH);
    localparam int RCW   = RAW + 1;
    localparam int GW    = $clog2(INTER_TRANSACTION_GAP + 1);
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CMD_W-1:0]               cmd_mem_q [CMD_FIFO_DEPTH];
    logic [CAW-1:0]                 cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CCW-1:0]                 cmd_cnt_q, cmd_cnt_d;
    logic                           cmd_ready_q, cmd_ready_d;
    logic                           cmd_push_s, cmd_pop_s;
    logic [CMD_W-1:0]               cmd_head_s;

    logic [INCOMING_DATA_WIDTH-1:0] rsp_mem_q [RSP_FIFO_DEPTH];
    logic [RAW-1:0]                 rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [RCW-1:0]                 rsp_cnt_q, rsp_cnt_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [INCOMING_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                           rsp_push_s, rsp_pop_s, rsp_full_s;
    logic [INCOMING_DATA_WIDTH-1:0] rsp_push_data_s;

    logic [NUMBER_OF_SLAVES-1:0]    hold_slave_q, hold_slave_d;
    logic                           hold_op_q, hold_op_d;
    logic [OUTGOING_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                           start_q, start_d;
    logic                           enable_q;
    logic                           busy_q, busy_d;
    logic [GW-1:0]                  gap_cnt_q, gap_cnt_d;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    logic [TW-1:0]                  tmo_cnt_q, tmo_cnt_d;
    logic                           tmo_err_q, tmo_err_d;
    logic                           tmo_fire_s;

    assign timeout_error = tmo_err_q;
`endif

    assign cmd_ready             = cmd_ready_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_data              = rsp_data_q;
    assign busy                  = busy_q;
    assign spi_enable            = enable_q;
    assign spi_start_transaction = start_q;
    assign spi_slave             = hold_slave_q;
    assign spi_operation         = hold_op_q;
    assign spi_outgoing_data     = hold_data_q;

    assign cmd_head_s = cmd_mem_q[cmd_rd_q];
    assign rsp_full_s = (rsp_cnt_q == RCW'(RSP_FIFO_DEPTH));

    // Command FIFO pointers, occupancy and registered ready
    always_comb begin
        cmd_push_s = cmd_valid && cmd_ready_q;
        if (cmd_push_s) begin
            cmd_wr_d = cmd_wr_q + CAW'(1'b1);
        end else begin
            cmd_wr_d = cmd_wr_q;
        end
        if (cmd_pop_s) begin
            cmd_rd_d = cmd_rd_q + CAW'(1'b1);
        end else begin
            cmd_rd_d = cmd_rd_q;
        end
        case ({cmd_push_s, cmd_pop_s})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CCW'(1'b1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CCW'(1'b1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
        cmd_ready_d = (cmd_cnt_d != CCW'(CMD_FIFO_DEPTH));
    end

    // Response FIFO pointers, occupancy and next registered head
    always_comb begin
        rsp_pop_s = rsp_valid_q && rsp_ready;
        if (rsp_push_s) begin
            rsp_wr_d = rsp_wr_q + RAW'(1'b1);
        end else begin
            rsp_wr_d = rsp_wr_q;
        end
        if (rsp_pop_s) begin
            rsp_rd_d = rsp_rd_q + RAW'(1'b1);
        end else begin
            rsp_rd_d = rsp_rd_q;
        end
        case ({rsp_push_s, rsp_pop_s})
            2'b10:   rsp_cnt_d = rsp_cnt_q + RCW'(1'b1);
            2'b01:   rsp_cnt_d = rsp_cnt_q - RCW'(1'b1);
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
        rsp_valid_d = (rsp_cnt_d != {RCW{1'b0}});
        // An entry written this cycle into an otherwise empty FIFO is not in rsp_mem_q yet
        if (!rsp_valid_d) begin
            rsp_data_d = {INCOMING_DATA_WIDTH{1'b0}};
        end else if (rsp_push_s && (rsp_cnt_q == RCW'(rsp_pop_s))) begin
            rsp_data_d = rsp_push_data_s;
        end else begin
            rsp_data_d = rsp_mem_q[rsp_rd_d];
        end
    end

    // Transaction sequencing: next state, hold registers, start pulse, FIFO pop/push requests
    always_comb begin
        state_d         = state_q;
        cmd_pop_s       = 1'b0;
        rsp_push_s      = 1'b0;
        rsp_push_data_s = spi_incoming_data;
        hold_slave_d    = hold_slave_q;
        hold_op_d       = hold_op_q;
        hold_data_d     = hold_data_q;
        start_d         = 1'b0;
        gap_cnt_d       = gap_cnt_q;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        tmo_fire_s      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A read is only issued when its response is guaranteed a slot
                if ((cmd_cnt_q != {CCW{1'b0}}) &&
                    (cmd_head_s[OUTGOING_DATA_WIDTH] || !rsp_full_s)) begin
                    state_d      = ST_ISSUE;
                    cmd_pop_s    = 1'b1;
                    hold_slave_d = cmd_head_s[CMD_W-1 -: NUMBER_OF_SLAVES];
                    hold_op_d    = cmd_head_s[OUTGOING_DATA_WIDTH];
                    hold_data_d  = cmd_head_s[OUTGOING_DATA_WIDTH-1:0];
                    start_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_BUSY;
                gap_cnt_d = {GW{1'b0}};
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
                tmo_cnt_d = {TW{1'b0}};
`endif
            end
            ST_BUSY: begin
                if (spi_end_of_transaction) begin
                    rsp_push_s = !hold_op_q;
                    state_d    = ST_GAP;
                end else begin
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
                    if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_fire_s      = 1'b1;
                        rsp_push_s      = !hold_op_q;
                        rsp_push_data_s = {INCOMING_DATA_WIDTH{1'b0}};
                        state_d         = ST_GAP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1'b1);
                    end
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(INTER_TRANSACTION_GAP - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = {GW{1'b0}};
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Busy reflects the state and queue contents that will hold after this edge
    always_comb begin
        busy_d = (state_d != ST_IDLE) || (cmd_cnt_d != {CCW{1'b0}});
    end

`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    // Sticky timeout flag; a new timeout wins over a simultaneous clear
    always_comb begin
        if (tmo_fire_s) begin
            tmo_err_d = 1'b1;
        end else if (error_clear) begin
            tmo_err_d = 1'b0;
        end else begin
            tmo_err_d = tmo_err_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= {TW{1'b0}};
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
`endif

    // Sequencer state and quick_spi-facing registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_slave_q <= {NUMBER_OF_SLAVES{1'b0}};
            hold_op_q    <= 1'b1;
            hold_data_q  <= {OUTGOING_DATA_WIDTH{1'b0}};
            start_q      <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            gap_cnt_q    <= {GW{1'b0}};
        end else begin
            state_q      <= state_d;
            hold_slave_q <= hold_slave_d;
            hold_op_q    <= hold_op_d;
            hold_data_q  <= hold_data_d;
            start_q      <= start_d;
            enable_q     <= 1'b1;
            busy_q       <= busy_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // Command FIFO storage and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CMD_FIFO_DEPTH; i++) begin
                cmd_mem_q[i] <= {CMD_W{1'b0}};
            end
            cmd_wr_q    <= {CAW{1'b0}};
            cmd_rd_q    <= {CAW{1'b0}};
            cmd_cnt_q   <= {CCW{1'b0}};
            cmd_ready_q <= 1'b1;
        end else begin
            if (cmd_push_s) begin
                cmd_mem_q[cmd_wr_q] <= {cmd_slave, cmd_operation, cmd_data};
            end
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_cnt_q   <= cmd_cnt_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Response FIFO storage and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                rsp_mem_q[i] <= {INCOMING_DATA_WIDTH{1'b0}};
            end
            rsp_wr_q    <= {RAW{1'b0}};
            rsp_rd_q    <= {RAW{1'b0}};
            rsp_cnt_q   <= {RCW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {INCOMING_DATA_WIDTH{1'b0}};
        end else begin
            if (rsp_push_s) begin
                rsp_mem_q[rsp_wr_q] <= rsp_push_data_s;
            end
            rsp_wr_q    <= rsp_wr_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_quick_spi_sequencer.sv
// Directed bench for quick_spi_sequencer with a quick_spi slave model and command/response scoreboards.
`timescale 1ns/1ps
module tb_quick_spi_sequencer;

    typedef struct packed {
        logic [1:0]  s;
        logic        op;
        logic [15:0] d;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_slave;
    logic        cmd_operation;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        busy, spi_enable, spi_start_transaction;
    logic [1:0]  spi_slave;
    logic        spi_operation;
    logic [15:0] spi_outgoing_data;
    logic        spi_end_of_transaction = 1'b0;
    logic [7:0]  spi_incoming_data = 8'hEE;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    logic        timeout_error;
    logic        error_clear;
`endif

    int   total = 0;
    int   bad   = 0;
    cmd_t exp_cmd_q[$];
    logic [7:0] exp_rsp_q[$];

    int   lat_cfg  = 3;
    bit   no_eot   = 1'b0;
    int   n_starts = 0;
    bit   m_active = 1'b0;
    int   m_cnt, m_lat;
    cmd_t m_cur;

    quick_spi_sequencer #(
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .NUMBER_OF_SLAVES(2),
        .OUTGOING_DATA_WIDTH(16),
        .INCOMING_DATA_WIDTH(8),
        .CMD_FIFO_DEPTH(4),
        .RSP_FIFO_DEPTH(4),
        .INTER_TRANSACTION_GAP(2)
    ) dut (
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
        .timeout_error(timeout_error),
        .error_clear(error_clear),
`endif
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_slave(cmd_slave),
        .cmd_operation(cmd_operation),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .busy(busy),
        .spi_enable(spi_enable),
        .spi_start_transaction(spi_start_transaction),
        .spi_slave(spi_slave),
        .spi_operation(spi_operation),
        .spi_outgoing_data(spi_outgoing_data),
        .spi_end_of_transaction(spi_end_of_transaction),
        .spi_incoming_data(spi_incoming_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] s, input logic op, input logic [15:0] d);
        int n;
        bit acc;
        cmd_slave     = s;
        cmd_operation = op;
        cmd_data      = d;
        cmd_valid     = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
        if (acc) begin
            exp_cmd_q.push_back({s, op, d});
            if (!op) exp_rsp_q.push_back(no_eot ? 8'h00 : d[7:0]);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
    endtask

    // quick_spi model: checks issued commands in order, holds eot off for m_lat cycles, echoes data low byte
    always @(negedge clk) begin
        spi_end_of_transaction = 1'b0;
        spi_incoming_data      = 8'hEE;
        if (!reset_n) begin
            m_active = 1'b0;
        end else if (m_active) begin
            chk("start_one_cycle", {31'd0, spi_start_transaction}, 32'd0);
            chk("hold_stable", {13'd0, spi_slave, spi_operation, spi_outgoing_data}, {13'd0, m_cur});
            m_cnt++;
            if (m_cnt == m_lat) begin
                spi_end_of_transaction = 1'b1;
                spi_incoming_data      = m_cur.d[7:0];
                m_active               = 1'b0;
            end
        end else if (spi_start_transaction) begin
            n_starts++;
            chk("start_expected", {31'd0, exp_cmd_q.size() != 0}, 32'd1);
            if (exp_cmd_q.size() != 0) begin
                chk("issue_order", {13'd0, spi_slave, spi_operation, spi_outgoing_data},
                    {13'd0, exp_cmd_q.pop_front()});
            end
            m_cur    = {spi_slave, spi_operation, spi_outgoing_data};
            m_cnt    = 0;
            m_lat    = lat_cfg;
            m_active = !no_eot;
        end
    end

    // Response consumer: every accepted response is checked against the scoreboard
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            chk("rsp_expected", {31'd0, exp_rsp_q.size() != 0}, 32'd1);
            if (exp_rsp_q.size() != 0) chk("rsp_order", {24'd0, rsp_data}, {24'd0, exp_rsp_q.pop_front()});
        end
    end

    initial begin
        int n;
        int n0;
        reset_n       = 1'b1;
        cmd_valid     = 1'b0;
        cmd_slave     = 2'd0;
        cmd_operation = 1'b1;
        cmd_data      = 16'd0;
        rsp_ready     = 1'b0;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
        error_clear   = 1'b0;
`endif
        #1 reset_n = 1'b0;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, spi_start_transaction}, 32'd0);
        chk("rst_enable", {31'd0, spi_enable}, 32'd0);
        chk("rst_spi_bus", {13'd0, spi_slave, spi_operation, spi_outgoing_data}, 32'h0001_0000);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("enable_after_rst", {31'd0, spi_enable}, 32'd1);

        // single write
        push_cmd(2'd1, 1'b1, 16'hA55A);
        chk("busy_after_push", {31'd0, busy}, 32'd1);
        tick();
        chk("start_latency", {31'd0, spi_start_transaction}, 32'd1);
        chk("wr_spi_bus", {13'd0, spi_slave, spi_operation, spi_outgoing_data}, 32'h0003_A55A);
        wait_idle();
        chk("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // single read
        push_cmd(2'd0, 1'b0, 16'h003C);
        wait_rsp();
        chk("rd_rsp_data", {24'd0, rsp_data}, 32'h3C);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_rsp_popped", {31'd0, rsp_valid}, 32'd0);
        wait_idle();

        // command FIFO fills behind a long transaction
        lat_cfg = 20;
        push_cmd(2'd2, 1'b1, 16'h1000);
        tick();
        tick();
        lat_cfg = 3;
        push_cmd(2'd0, 1'b1, 16'h2001);
        push_cmd(2'd1, 1'b1, 16'h2002);
        push_cmd(2'd2, 1'b1, 16'h2003);
        push_cmd(2'd3, 1'b1, 16'h2004);
        chk("cmd_full", {31'd0, cmd_ready}, 32'd0);
        push_cmd(2'd1, 1'b1, 16'h2005);
        wait_idle();
        chk("fifo_all_issued", exp_cmd_q.size(), 32'd0);

        // response FIFO back-pressure blocks the fifth read
        n0 = n_starts;
        push_cmd(2'd0, 1'b0, 16'h0011);
        push_cmd(2'd1, 1'b0, 16'h0022);
        push_cmd(2'd2, 1'b0, 16'h0033);
        push_cmd(2'd3, 1'b0, 16'h0044);
        push_cmd(2'd0, 1'b0, 16'h0055);
        repeat (80) tick();
        chk("rd_stall_starts", n_starts - n0, 32'd4);
        chk("rd_stall_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_stall_head", {24'd0, rsp_data}, 32'h11);
        chk("rd_stall_busy", {31'd0, busy}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n = 0;
        while ((n_starts - n0) < 5 && n < 60) begin
            tick();
            n++;
        end
        chk("rd_fifth_issued", n_starts - n0, 32'd5);
        rsp_ready = 1'b1;
        n = 0;
        while (exp_rsp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        chk("rd_drained", exp_rsp_q.size(), 32'd0);
        tick();
        chk("rd_empty", {31'd0, rsp_valid}, 32'd0);
        wait_idle();

`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
        // watchdog on a transaction that never ends
        no_eot = 1'b1;
        push_cmd(2'd2, 1'b0, 16'h0099);
        tick();
        n = 0;
        while (!timeout_error && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 32'd17);
        no_eot = 1'b0;
        wait_rsp();
        chk("tmo_rsp_zero", {24'd0, rsp_data}, 32'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk("tmo_sticky", {31'd0, timeout_error}, 32'd1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("tmo_cleared", {31'd0, timeout_error}, 32'd0);
        wait_idle();
`endif

        // asynchronous reset in the middle of a transaction with a queued command
        lat_cfg = 30;
        push_cmd(2'd1, 1'b1, 16'h1234);
        push_cmd(2'd2, 1'b0, 16'h5678);
        lat_cfg = 3;
        repeat (3) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_bus", {13'd0, spi_slave, spi_operation, spi_outgoing_data}, 32'h0003_1234);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_enable", {31'd0, spi_enable}, 32'd0);
        chk("arst_spi_bus", {13'd0, spi_slave, spi_operation, spi_outgoing_data}, 32'h0001_0000);
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        tick();
        reset_n = 1'b1;
        n0 = n_starts;
        repeat (10) tick();
        chk("post_rst_no_issue", n_starts - n0, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_enable", {31'd0, spi_enable}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
